clap_count_sequencer: RTL and testbench

//  Sequences the clap count for the LED bar-graph driver. Takes 1-cycle clap

---
 rtl/clap_count_sequencer_if.sv | 45 ++++
 rtl/clap_count_sequencer.sv | 176 +++++++++++++++++
 tb/tb_clap_count_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clap_count_sequencer_if.sv
// ---------------------------------------------------------------------------
// clap_count_sequencer_if
//
// Purpose:
//   Bundles the clap-sequencer control inputs and display/status outputs so
//   the sequencer and whatever drives it share one connection.
//
// Signals:
//   clap      1  clap strobe, one clock wide, synchronous to clk
//   clear     1  synchronous abort back to IDLE with count cleared
//   count     4  current clap count for the LED bar driver
//   seq_done  1  one-cycle pulse when a sequence closes
//   busy      1  high whenever the sequencer is not IDLE
//   state     2  FSM state for debug (00 IDLE, 01 LOCKOUT, 10 ARMED, 11 HOLD)
//
// Modports:
//   master  drives clap/clear, observes the outputs (detector / test side)
//   slave   the sequencer itself
// ---------------------------------------------------------------------------
interface clap_count_sequencer_if;
    logic       clap;
    logic       clear;
    logic [3:0] count;
    logic       seq_done;
    logic       busy;
    logic [1:0] state;

    modport master (
        output clap,
        output clear,
        input  count,
        input  seq_done,
        input  busy,
        input  state
    );

    modport slave (
        input  clap,
        input  clear,
        output count,
        output seq_done,
        output busy,
        output state
    );
endinterface

// File: rtl/clap_count_sequencer.sv
// ---------------------------------------------------------------------------
// clap_count_sequencer
//
// Purpose:
//   Turns single-cycle clap strobes into a clap count for the LED bar graph.
//   After every accepted clap, further claps are ignored for a lockout period
//   so that echoes are rejected. Claps accumulate until a silence window
//   expires, at which point the sequence closes (seq_done pulse) and the final
//   count is held for display before clearing automatically.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous, active-low reset
//   bus   slave modport of clap_count_sequencer_if
//           clap, clear in; count, seq_done, busy, state out (all registered)
//
// Parameters:
//   LOCKOUT_CYC  cycles claps are ignored after an accepted clap (>=1)
//   WINDOW_CYC   cycles allowed in ARMED without a clap before closing (>=1)
//   HOLD_CYC     cycles the final count is displayed after closing (>=1)
//   MAX_COUNT    count ceiling, 1..15
//
// Configuration:
//   CLAP_COUNT_WRAP_EN  when defined, a clap accepted at the ceiling wraps the
//                       count to 1; otherwise the count saturates at MAX_COUNT.
// ---------------------------------------------------------------------------
module clap_count_sequencer #(
    parameter int LOCKOUT_CYC = 50_000,
    parameter int WINDOW_CYC  = 2_500_000,
    parameter int HOLD_CYC    = 5_000_000,
    parameter int MAX_COUNT   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    clap_count_sequencer_if.slave   bus
);

    // One timer is shared by all three timed phases, so it is sized for the
    // longest of them.
    localparam int MAX_LW   = (LOCKOUT_CYC > WINDOW_CYC) ? LOCKOUT_CYC : WINDOW_CYC;
    localparam int MAX_ALL  = (MAX_LW > HOLD_CYC) ? MAX_LW : HOLD_CYC;
    localparam int TW       = $clog2(MAX_ALL + 1);

    // Loading N-1 and leaving on the cycle the timer reads zero gives exactly
    // N cycles in the phase.
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYC - 1);
    localparam logic [TW-1:0] WINDOW_LOAD  = TW'(WINDOW_CYC - 1);
    localparam logic [TW-1:0] HOLD_LOAD    = TW'(HOLD_CYC - 1);
    localparam logic [3:0]    COUNT_MAX    = 4'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOCKOUT = 2'b01,
        ARMED   = 2'b10,
        HOLD    = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      count_q, count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            seq_done_q, seq_done_d;
    logic            busy_q, busy_d;

    // Count after a clap accepted in ARMED: either saturate or wrap at the
    // ceiling depending on build configuration.
    logic [3:0]      count_inc;

    always_comb begin
        count_inc = count_q + 4'd1;
        if (count_q >= COUNT_MAX) begin
`ifdef CLAP_COUNT_WRAP_EN
            count_inc = 4'd1;
`else
            count_inc = COUNT_MAX;
`endif
        end
    end

    // Next-state logic. clear overrides everything, including a clap on the
    // same cycle. seq_done defaults low so it can only ever be a single-cycle
    // pulse on the ARMED to HOLD transition.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        timer_d    = timer_q;
        seq_done_d = 1'b0;

        if (bus.clear) begin
            state_d = IDLE;
            count_d = 4'd0;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.clap) begin
                        state_d = LOCKOUT;
                        count_d = 4'd1;
                        timer_d = LOCKOUT_LOAD;
                    end
                end

                // Claps here are treated as echoes of the one just counted.
                LOCKOUT: begin
                    if (timer_q == '0) begin
                        state_d = ARMED;
                        timer_d = WINDOW_LOAD;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end

                // A clap on the very cycle the window expires is still
                // counted; the sequence only closes on genuine silence.
                ARMED: begin
                    if (bus.clap) begin
                        state_d = LOCKOUT;
                        count_d = count_inc;
                        timer_d = LOCKOUT_LOAD;
                    end else if (timer_q == '0) begin
                        state_d    = HOLD;
                        seq_done_d = 1'b1;
                        timer_d    = HOLD_LOAD;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end

                // A clap while the result is on display starts a fresh
                // sequence without announcing another completion.
                HOLD: begin
                    if (bus.clap) begin
                        state_d = LOCKOUT;
                        count_d = 4'd1;
                        timer_d = LOCKOUT_LOAD;
                    end else if (timer_q == '0) begin
                        state_d = IDLE;
                        count_d = 4'd0;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end

                default: begin
                    state_d = IDLE;
                    count_d = 4'd0;
                    timer_d = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= 4'd0;
            timer_q    <= '0;
            seq_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            seq_done_q <= seq_done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.seq_done = seq_done_q;
    assign bus.busy     = busy_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_clap_count_sequencer.sv
// ---------------------------------------------------------------------------
// tb_clap_count_sequencer
//
// Purpose:
//   Self-checking bench for clap_count_sequencer with short timing parameters
//   (LOCKOUT 4, WINDOW 10, HOLD 6, MAX_COUNT 8). Each vector gives the inputs
//   sampled at one clock edge and the outputs expected right after it.
//   Expected outputs are queued when a vector is driven and compared when
//   the DUT has produced its response. Define CLAP_COUNT_WRAP_EN for the
//   wrapping-count build.
// ---------------------------------------------------------------------------
module tb_clap_count_sequencer;

    localparam int LOCK_C = 4;
    localparam int WIN_C  = 10;
    localparam int HOLD_C = 6;
    localparam int MAXC   = 8;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_LOCK  = 2'b01;
    localparam logic [1:0] S_ARMED = 2'b10;
    localparam logic [1:0] S_HOLD  = 2'b11;

    typedef struct packed {
        logic [3:0] count;
        logic [1:0] state;
        logic       seq_done;
        logic       busy;
    } exp_t;

    typedef struct {
        logic clap;
        logic clear;
        exp_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    vec_t vecs[$];
    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    clap_count_sequencer_if bus();

    clap_count_sequencer #(
        .LOCKOUT_CYC (LOCK_C),
        .WINDOW_CYC  (WIN_C),
        .HOLD_CYC    (HOLD_C),
        .MAX_COUNT   (MAXC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Append n identical vectors. busy is expected whenever the state is
    // not IDLE.
    function automatic void addVec(input logic c, input logic clr, input int n,
                                   input int cnt, input logic [1:0] st,
                                   input logic sd);
        vec_t v;
        v.clap           = c;
        v.clear          = clr;
        v.exp.count      = 4'(cnt);
        v.exp.state      = st;
        v.exp.seq_done   = sd;
        v.exp.busy       = (st != S_IDLE);
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    function automatic exp_t mkExp(input int cnt, input logic [1:0] st, input logic sd);
        exp_t e;
        e.count    = 4'(cnt);
        e.state    = st;
        e.seq_done = sd;
        e.busy     = (st != S_IDLE);
        return e;
    endfunction

    // Expected count after the k-th accepted clap of one sequence.
    function automatic int clapCount(input int k);
`ifdef CLAP_COUNT_WRAP_EN
        return ((k - 1) % MAXC) + 1;
`else
        return (k > MAXC) ? MAXC : k;
`endif
    endfunction

    // Pop the oldest expectation and compare it against the DUT outputs.
    task automatic checkOutput(input string name);
        exp_t e;
        exp_t act;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: got an output with no queued expectation", name);
        end else begin
            e   = expQ.pop_front();
            act = {bus.count, bus.state, bus.seq_done, bus.busy};
            if (act !== e) begin
                errors++;
                $display("[TB] FAIL %s: got count=%0d state=%0d seq_done=%0b busy=%0b, expected count=%0d state=%0d seq_done=%0b busy=%0b",
                         name, act.count, act.state, act.seq_done, act.busy,
                         e.count, e.state, e.seq_done, e.busy);
            end
        end
    endtask

    // Drive one vector half a cycle before the edge that samples it, then
    // check just after that edge.
    task automatic applyStimulus(input vec_t v, input string name);
        @(negedge clk);
        bus.clap  = v.clap;
        bus.clear = v.clear;
        expQ.push_back(v.exp);
        @(posedge clk);
        #1;
        checkOutput(name);
    endtask

    // Guard against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   e10;
        vec_t hv;

        bus.clap  = 1'b0;
        bus.clear = 1'b0;
        rst       = 1'b0;

        // Single clap: 4 cycles of lockout, 10 of window, seq_done, 6 of hold.
        addVec(1, 0, 1, 1, S_LOCK,  0);
        addVec(0, 0, 3, 1, S_LOCK,  0);
        addVec(0, 0, 10, 1, S_ARMED, 0);
        addVec(0, 0, 1, 1, S_HOLD,  1);
        addVec(0, 0, 5, 1, S_HOLD,  0);
        addVec(0, 0, 2, 0, S_IDLE,  0);

        // Three claps 6 cycles apart, with echoes inside lockout ignored.
        addVec(1, 0, 1, 1, S_LOCK,  0);
        addVec(0, 0, 1, 1, S_LOCK,  0);
        addVec(1, 0, 1, 1, S_LOCK,  0);
        addVec(0, 0, 1, 1, S_LOCK,  0);
        addVec(0, 0, 2, 1, S_ARMED, 0);
        addVec(1, 0, 1, 2, S_LOCK,  0);
        addVec(0, 0, 1, 2, S_LOCK,  0);
        addVec(1, 0, 1, 2, S_LOCK,  0);
        addVec(0, 0, 1, 2, S_LOCK,  0);
        addVec(0, 0, 2, 2, S_ARMED, 0);
        addVec(1, 0, 1, 3, S_LOCK,  0);
        addVec(0, 0, 3, 3, S_LOCK,  0);
        addVec(0, 0, 10, 3, S_ARMED, 0);
        addVec(0, 0, 1, 3, S_HOLD,  1);
        addVec(0, 0, 5, 3, S_HOLD,  0);
        addVec(0, 0, 1, 0, S_IDLE,  0);

        // Ten accepted claps: ceiling behaviour, lockout still restarts.
        for (int k = 1; k <= 10; k++) begin
            addVec(1, 0, 1, clapCount(k), S_LOCK, 0);
            addVec(0, 0, 3, clapCount(k), S_LOCK, 0);
            if (k < 10) addVec(0, 0, 1, clapCount(k), S_ARMED, 0);
        end
        e10 = clapCount(10);
        addVec(0, 0, 10, e10, S_ARMED, 0);
        addVec(0, 0, 1, e10, S_HOLD,  1);
        addVec(0, 0, 5, e10, S_HOLD,  0);
        addVec(0, 0, 1, 0,   S_IDLE,  0);

        // Clap on the window expiry cycle is counted, no seq_done.
        addVec(1, 0, 1, 1, S_LOCK,  0);
        addVec(0, 0, 3, 1, S_LOCK,  0);
        addVec(0, 0, 10, 1, S_ARMED, 0);
        addVec(1, 0, 1, 2, S_LOCK,  0);
        addVec(0, 0, 3, 2, S_LOCK,  0);
        addVec(0, 0, 10, 2, S_ARMED, 0);
        addVec(0, 0, 1, 2, S_HOLD,  1);
        addVec(0, 0, 1, 2, S_HOLD,  0);
        // Clap during hold restarts at 1 without a second seq_done.
        addVec(1, 0, 1, 1, S_LOCK,  0);
        addVec(0, 0, 1, 1, S_LOCK,  0);
        // Clear with a simultaneous clap in lockout.
        addVec(1, 1, 1, 0, S_IDLE,  0);
        addVec(0, 0, 1, 0, S_IDLE,  0);
        // Clear while armed, and clear+clap in idle.
        addVec(1, 0, 1, 1, S_LOCK,  0);
        addVec(0, 0, 3, 1, S_LOCK,  0);
        addVec(0, 0, 2, 1, S_ARMED, 0);
        addVec(0, 1, 1, 0, S_IDLE,  0);
        addVec(1, 1, 1, 0, S_IDLE,  0);
        addVec(0, 0, 1, 0, S_IDLE,  0);

        // Outputs while held in reset.
        #12;
        expQ.push_back(mkExp(0, S_IDLE, 0));
        checkOutput("reset_state");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset pulled mid-ARMED: outputs clear without an edge.
        hv.clear = 1'b0;
        hv.clap = 1'b1; hv.exp = mkExp(1, S_LOCK, 0);
        applyStimulus(hv, "rst_seq_clap");
        hv.clap = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(hv, "rst_seq_lock");
        hv.exp = mkExp(1, S_ARMED, 0);
        applyStimulus(hv, "rst_seq_armed0");
        applyStimulus(hv, "rst_seq_armed1");
        @(negedge clk);
        #2;
        rst = 1'b0;
        expQ.push_back(mkExp(0, S_IDLE, 0));
        #1;
        checkOutput("async_reset_mid_armed");
        @(posedge clk);
        #1;
        expQ.push_back(mkExp(0, S_IDLE, 0));
        checkOutput("reset_held");
        @(negedge clk);
        rst = 1'b1;
        hv.exp = mkExp(0, S_IDLE, 0);
        applyStimulus(hv, "after_reset_idle");
        hv.clap = 1'b1; hv.exp = mkExp(1, S_LOCK, 0);
        applyStimulus(hv, "after_reset_clap");

        @(negedge clk);
        bus.clap  = 1'b0;
        bus.clear = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
